// File: rtl/l2_access_sequencer_if.sv
// Signal bundle between the L2 access sequencer and its environment
// (L1 requests, snoops, tag lookup, line-state update, shared bus, L1 response).
interface l2_access_sequencer_if #(
    parameter int ADDR_BITS = 32,
    parameter int WAYS      = 8
);
    logic                     l1_valid;
    logic                     l1_ready;
    logic [7:0]               l1_op;
    logic [ADDR_BITS-1:0]     l1_addr;
    logic                     snp_valid;
    logic                     snp_ready;
    logic [7:0]               snp_op;
    logic [ADDR_BITS-1:0]     snp_addr;
    logic                     lk_start;
    logic                     lk_done;
    logic                     lk_hit;
    logic [$clog2(WAYS)-1:0]  lk_way;
    logic [1:0]               lk_mesi;
    logic [ADDR_BITS-1:0]     lk_vaddr;
    logic [ADDR_BITS-1:0]     addr;
    logic                     upd_en;
    logic [$clog2(WAYS)-1:0]  upd_way;
    logic [1:0]               upd_mesi;
    logic                     upd_lru;
    logic                     bus_req;
    logic [7:0]               bus_op;
    logic                     bus_done;
    logic                     resp_valid;
    logic                     resp_hit;

    // The sequencer side.
    modport slave (
        input  l1_valid, l1_op, l1_addr, snp_valid, snp_op, snp_addr,
               lk_done, lk_hit, lk_way, lk_mesi, lk_vaddr, bus_done,
        output l1_ready, snp_ready, lk_start, addr, upd_en, upd_way,
               upd_mesi, upd_lru, bus_req, bus_op, resp_valid, resp_hit
    );

    // The environment side (L1, snoop source, tag array, bus).
    modport master (
        output l1_valid, l1_op, l1_addr, snp_valid, snp_op, snp_addr,
               lk_done, lk_hit, lk_way, lk_mesi, lk_vaddr, bus_done,
        input  l1_ready, snp_ready, lk_start, addr, upd_en, upd_way,
               upd_mesi, upd_lru, bus_req, bus_op, resp_valid, resp_hit
    );
endinterface

// File: rtl/l2_access_sequencer.sv
// L2 access sequencer: serialises snoops and L1 requests through tag lookup,
// optional writeback / line fetch on the shared bus, MESI update and L1 response.
module l2_access_sequencer #(
    parameter int ADDR_BITS = 32,
    parameter int WAYS      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    l2_access_sequencer_if.slave  sif
);
    localparam int WAY_BITS = $clog2(WAYS);

    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_M = 8'h4D;
    localparam logic [7:0] OP_I = 8'h49;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FETCH, UPDATE, RESP} state_t;

    state_t                 state_reg,  state_next;
    logic                   is_snp_reg, is_snp_next;
    logic [7:0]             op_reg,     op_next;
    logic [ADDR_BITS-1:0]   addr_reg,   addr_next;
    logic                   lk_first_reg, lk_first_next;
    logic                   hit_reg,    hit_next;
    logic [WAY_BITS-1:0]    way_reg,    way_next;
    logic [1:0]             mesi_reg,   mesi_next;
    logic [ADDR_BITS-1:0]   vaddr_reg,  vaddr_next;
    logic                   bus_gap_reg, bus_gap_next;
    logic                   snp_legal;

    assign snp_legal = (op_reg == OP_R) || (op_reg == OP_W) ||
                       (op_reg == OP_M) || (op_reg == OP_I);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            is_snp_reg   <= 1'b0;
            op_reg       <= 8'h00;
            addr_reg     <= '0;
            lk_first_reg <= 1'b0;
            hit_reg      <= 1'b0;
            way_reg      <= '0;
            mesi_reg     <= MESI_I;
            vaddr_reg    <= '0;
            bus_gap_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            is_snp_reg   <= is_snp_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            lk_first_reg <= lk_first_next;
            hit_reg      <= hit_next;
            way_reg      <= way_next;
            mesi_reg     <= mesi_next;
            vaddr_reg    <= vaddr_next;
            bus_gap_reg  <= bus_gap_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        is_snp_next   = is_snp_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        lk_first_next = 1'b0;
        hit_next      = hit_reg;
        way_next      = way_reg;
        mesi_next     = mesi_reg;
        vaddr_next    = vaddr_reg;
        bus_gap_next  = 1'b0;

        sif.l1_ready   = 1'b0;
        sif.snp_ready  = 1'b0;
        sif.lk_start   = 1'b0;
        sif.addr       = '0;
        sif.upd_en     = 1'b0;
        sif.upd_way    = '0;
        sif.upd_mesi   = MESI_I;
        sif.upd_lru    = 1'b0;
        sif.bus_req    = 1'b0;
        sif.bus_op     = 8'h00;
        sif.resp_valid = 1'b0;
        sif.resp_hit   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Ready reflects what is actually accepted: a snoop wins the cycle.
                sif.snp_ready = !reset;
                sif.l1_ready  = !reset && !sif.snp_valid;
                if (sif.snp_valid) begin
                    is_snp_next   = 1'b1;
                    op_next       = sif.snp_op;
                    addr_next     = sif.snp_addr;
                    lk_first_next = 1'b1;
                    state_next    = LOOKUP;
                end else if (sif.l1_valid) begin
                    is_snp_next   = 1'b0;
                    op_next       = (sif.l1_op == OP_W) ? OP_W : OP_R;
                    addr_next     = sif.l1_addr;
                    lk_first_next = 1'b1;
                    state_next    = LOOKUP;
                end
            end
            LOOKUP: begin
                sif.lk_start = lk_first_reg;
                sif.addr     = addr_reg;
                if (sif.lk_done) begin
                    hit_next   = sif.lk_hit;
                    way_next   = sif.lk_way;
                    mesi_next  = sif.lk_mesi;
                    vaddr_next = sif.lk_vaddr;
                    if (is_snp_reg) begin
                        if (!sif.lk_hit || !snp_legal)
                            state_next = IDLE;
                        else if (sif.lk_mesi == MESI_M && (op_reg == OP_R || op_reg == OP_M))
                            state_next = WB;
                        else
                            state_next = UPDATE;
                    end else begin
                        if (sif.lk_hit)
                            state_next = UPDATE;
                        else if (sif.lk_mesi == MESI_M)
                            state_next = WB;
                        else
                            state_next = FETCH;
                    end
                end
            end
            WB: begin
                sif.bus_req = 1'b1;
                sif.bus_op  = OP_W;
                sif.addr    = is_snp_reg ? addr_reg : vaddr_reg;
                if (sif.bus_done) begin
                    state_next   = is_snp_reg ? UPDATE : FETCH;
                    // Force one idle bus cycle between writeback and fetch.
                    bus_gap_next = !is_snp_reg;
                end
            end
            FETCH: begin
                sif.bus_req = !bus_gap_reg;
                sif.bus_op  = (op_reg == OP_W) ? OP_M : OP_R;
                sif.addr    = addr_reg;
                if (sif.bus_done && !bus_gap_reg)
                    state_next = UPDATE;
            end
            UPDATE: begin
                sif.upd_en  = 1'b1;
                sif.upd_way = way_reg;
                sif.upd_lru = !is_snp_reg;
                if (is_snp_reg)
                    sif.upd_mesi = (op_reg == OP_R) ? MESI_S : MESI_I;
                else if (op_reg == OP_W)
                    sif.upd_mesi = MESI_M;
                else
                    sif.upd_mesi = hit_reg ? mesi_reg : MESI_E;
                state_next = is_snp_reg ? IDLE : RESP;
            end
            RESP: begin
                sif.resp_valid = 1'b1;
                sif.resp_hit   = hit_reg;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
